// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at start and
// held in a pending register until a fixed-latency busy countdown commits them.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_start,
    output logic        E_busy,
    output logic        E_md_stall,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic               is_mul, is_div, commit;
    logic signed [63:0] ext_a, ext_b, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, sdiv_b, udiv_b;
    logic [31:0]        q_mag, r_mag, s_quo, s_rem, u_quo, u_rem;
    logic [31:0]        res_hi, res_lo;

    always_comb begin
        is_mul     = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
        is_div     = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
        E_busy     = (cnt_q != '0);
        E_start    = (is_mul || is_div) && !E_busy;
        E_md_stall = E_start || E_busy;
        commit     = (cnt_q == CNT_W'(1));
        E_HI       = hi_q;
        E_LO       = lo_q;
    end

    // Signed divide works on magnitudes, so the 0x80000000 / -1 case
    // falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        ext_a  = {{32{E_A[31]}}, E_A};
        ext_b  = {{32{E_B[31]}}, E_B};
        prod_s = ext_a * ext_b;
        prod_u = {32'd0, E_A} * {32'd0, E_B};

        abs_a  = E_A[31] ? (32'd0 - E_A) : E_A;
        abs_b  = E_B[31] ? (32'd0 - E_B) : E_B;
        sdiv_b = (E_B == 32'd0) ? 32'd1 : abs_b;
        udiv_b = (E_B == 32'd0) ? 32'd1 : E_B;
        q_mag  = abs_a / sdiv_b;
        r_mag  = abs_a % sdiv_b;
        s_quo  = (E_A[31] ^ E_B[31]) ? (32'd0 - q_mag) : q_mag;
        s_rem  = E_A[31] ? (32'd0 - r_mag) : r_mag;
        u_quo  = E_A / udiv_b;
        u_rem  = E_A % udiv_b;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (E_md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = s_rem;
                res_lo = s_quo;
            end
            OP_DIVU: begin
                res_hi = u_rem;
                res_lo = u_quo;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase

        if (is_div && (E_B == 32'd0)) begin
            res_hi = E_A;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    // HI/LO only move on a commit or an idle mthi/mtlo; the commit edge itself
    // still counts as busy, so a move-to on that edge is dropped.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        if (E_start) begin
            cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
        end else if (E_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (commit) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (!E_busy && (E_md_op == OP_MTHI)) begin
            hi_d = E_A;
        end else if (!E_busy && (E_md_op == OP_MTLO)) begin
            lo_d = E_A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, arithmetic corners,
// busy interference, commit-edge back-to-back and asynchronous reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_start;
    logic        E_busy;
    logic        E_md_stall;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_md_op    (E_md_op),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_start    (E_start),
        .E_busy     (E_busy),
        .E_md_stall (E_md_stall),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an op for one edge, then counts busy cycles (bounded) until idle.
    task automatic drive_and_count(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic start_seen,
                                   output int cycles);
        E_md_op = op;
        E_A     = a;
        E_B     = b;
        #1;
        start_seen = E_start;
        tick();
        E_md_op = 3'd0;
        cycles  = 0;
        while (E_busy && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        E_md_op = 3'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        tick();
        tick();
        total_cnt++; if (E_HI !== 32'd0) $display("[TB] FAIL reset_hi got %h expected %h", E_HI, 32'd0); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd0) $display("[TB] FAIL reset_lo got %h expected %h", E_LO, 32'd0); else pass_cnt++;
        total_cnt++; if (E_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", E_busy); else pass_cnt++;
        total_cnt++; if (E_md_stall !== 1'b0) $display("[TB] FAIL reset_stall got %b expected 0", E_md_stall); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic st;
        int   n;
        drive_and_count(3'd1, 32'hFFFF_FFFE, 32'd3, st, n);
        total_cnt++; if (st !== 1'b1) $display("[TB] FAIL mult_start got %b expected 1", st); else pass_cnt++;
        total_cnt++; if (n != 5) $display("[TB] FAIL mult_busy_cycles got %0d expected 5", n); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_hi got %h expected ffffffff", E_HI); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'hFFFF_FFFA) $display("[TB] FAIL mult_lo got %h expected fffffffa", E_LO); else pass_cnt++;

        drive_and_count(3'd2, 32'hFFFF_FFFE, 32'd3, st, n);
        total_cnt++; if (n != 5) $display("[TB] FAIL multu_busy_cycles got %0d expected 5", n); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'h0000_0002) $display("[TB] FAIL multu_hi got %h expected 00000002", E_HI); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'hFFFF_FFFA) $display("[TB] FAIL multu_lo got %h expected fffffffa", E_LO); else pass_cnt++;
    endtask

    task automatic test_div();
        logic st;
        int   n;
        drive_and_count(3'd3, 32'hFFFF_FFF9, 32'd2, st, n);
        total_cnt++; if (st !== 1'b1) $display("[TB] FAIL div_start got %b expected 1", st); else pass_cnt++;
        total_cnt++; if (n != 10) $display("[TB] FAIL div_busy_cycles got %0d expected 10", n); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'hFFFF_FFFD) $display("[TB] FAIL div_lo got %h expected fffffffd", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'hFFFF_FFFF) $display("[TB] FAIL div_hi got %h expected ffffffff", E_HI); else pass_cnt++;

        drive_and_count(3'd4, 32'd7, 32'd2, st, n);
        total_cnt++; if (E_LO !== 32'd3) $display("[TB] FAIL divu_lo got %h expected 00000003", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd1) $display("[TB] FAIL divu_hi got %h expected 00000001", E_HI); else pass_cnt++;
    endtask

    task automatic test_div_corners();
        logic st;
        int   n;
        drive_and_count(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, st, n);
        total_cnt++; if (n != 10) $display("[TB] FAIL ovf_busy_cycles got %0d expected 10", n); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'h8000_0000) $display("[TB] FAIL ovf_lo got %h expected 80000000", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd0) $display("[TB] FAIL ovf_hi got %h expected 00000000", E_HI); else pass_cnt++;

        drive_and_count(3'd3, 32'hFFFF_FFF9, 32'd0, st, n);
        total_cnt++; if (E_LO !== 32'hFFFF_FFFF) $display("[TB] FAIL div0s_lo got %h expected ffffffff", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'hFFFF_FFF9) $display("[TB] FAIL div0s_hi got %h expected fffffff9", E_HI); else pass_cnt++;

        drive_and_count(3'd4, 32'd5, 32'd0, st, n);
        total_cnt++; if (n != 10) $display("[TB] FAIL div0u_busy_cycles got %0d expected 10", n); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'hFFFF_FFFF) $display("[TB] FAIL div0u_lo got %h expected ffffffff", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd5) $display("[TB] FAIL div0u_hi got %h expected 00000005", E_HI); else pass_cnt++;
    endtask

    task automatic test_busy_interference();
        int n;
        E_md_op = 3'd1;
        E_A     = 32'd2;
        E_B     = 32'd3;
        tick();
        E_md_op = 3'd5;
        E_A     = 32'h1234;
        #1;
        total_cnt++; if (E_start !== 1'b0) $display("[TB] FAIL intf_mthi_start got %b expected 0", E_start); else pass_cnt++;
        total_cnt++; if (E_md_stall !== 1'b1) $display("[TB] FAIL intf_mthi_stall got %b expected 1", E_md_stall); else pass_cnt++;
        tick();
        total_cnt++; if (E_HI !== 32'd5) $display("[TB] FAIL intf_hi_held got %h expected 00000005", E_HI); else pass_cnt++;
        E_md_op = 3'd3;
        E_A     = 32'd9;
        E_B     = 32'd3;
        #1;
        total_cnt++; if (E_start !== 1'b0) $display("[TB] FAIL intf_div_start got %b expected 0", E_start); else pass_cnt++;
        total_cnt++; if (E_md_stall !== 1'b1) $display("[TB] FAIL intf_div_stall got %b expected 1", E_md_stall); else pass_cnt++;
        tick();
        E_md_op = 3'd0;
        n = 0;
        while (E_busy && n < 50) begin
            n++;
            tick();
        end
        total_cnt++; if (n != 3) $display("[TB] FAIL intf_remaining_busy got %0d expected 3", n); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd0) $display("[TB] FAIL intf_hi got %h expected 00000000", E_HI); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd6) $display("[TB] FAIL intf_lo got %h expected 00000006", E_LO); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic st;
        int   n;
        E_md_op = 3'd1;
        E_A     = 32'd4;
        E_B     = 32'd5;
        tick();
        E_md_op = 3'd0;
        repeat (4) tick();
        E_md_op = 3'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        #1;
        total_cnt++; if (E_start !== 1'b0) $display("[TB] FAIL b2b_commit_start got %b expected 0", E_start); else pass_cnt++;
        tick();
        total_cnt++; if (E_busy !== 1'b0) $display("[TB] FAIL b2b_after_commit_busy got %b expected 0", E_busy); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd20) $display("[TB] FAIL b2b_mult_lo got %h expected 00000014", E_LO); else pass_cnt++;
        drive_and_count(3'd3, 32'd100, 32'd7, st, n);
        total_cnt++; if (st !== 1'b1) $display("[TB] FAIL b2b_retry_start got %b expected 1", st); else pass_cnt++;
        total_cnt++; if (n != 10) $display("[TB] FAIL b2b_retry_busy got %0d expected 10", n); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd14) $display("[TB] FAIL b2b_div_lo got %h expected 0000000e", E_LO); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd2) $display("[TB] FAIL b2b_div_hi got %h expected 00000002", E_HI); else pass_cnt++;

        E_md_op = 3'd6;
        E_A     = 32'hABCD;
        #1;
        total_cnt++; if (E_start !== 1'b0) $display("[TB] FAIL mtlo_start got %b expected 0", E_start); else pass_cnt++;
        tick();
        E_md_op = 3'd0;
        total_cnt++; if (E_LO !== 32'hABCD) $display("[TB] FAIL mtlo_lo got %h expected 0000abcd", E_LO); else pass_cnt++;
        total_cnt++; if (E_busy !== 1'b0) $display("[TB] FAIL mtlo_busy got %b expected 0", E_busy); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd2) $display("[TB] FAIL mtlo_hi_kept got %h expected 00000002", E_HI); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        E_md_op = 3'd3;
        E_A     = 32'd9;
        E_B     = 32'd3;
        tick();
        E_md_op = 3'd0;
        repeat (3) tick();
        total_cnt++; if (E_busy !== 1'b1) $display("[TB] FAIL rstmid_pre_busy got %b expected 1", E_busy); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (E_busy !== 1'b0) $display("[TB] FAIL rstmid_busy got %b expected 0", E_busy); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd0) $display("[TB] FAIL rstmid_hi got %h expected 00000000", E_HI); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd0) $display("[TB] FAIL rstmid_lo got %h expected 00000000", E_LO); else pass_cnt++;
        tick();
        reset = 1'b1;
        repeat (15) tick();
        total_cnt++; if (E_busy !== 1'b0) $display("[TB] FAIL rstmid_late_busy got %b expected 0", E_busy); else pass_cnt++;
        total_cnt++; if (E_HI !== 32'd0) $display("[TB] FAIL rstmid_late_hi got %h expected 00000000", E_HI); else pass_cnt++;
        total_cnt++; if (E_LO !== 32'd0) $display("[TB] FAIL rstmid_late_lo got %h expected 00000000", E_LO); else pass_cnt++;
    endtask

    initial begin
        reset   = 1'b0;
        E_md_op = 3'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_corners();
        test_busy_interference();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit owning the HI/LO registers. Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Models fixed multi-cycle latency with a busy counter. Exposes HI/LO for mfhi/mflo, which the forwarding path treats as E_Tnew=1 results.
- Exposes busy/start so the stall controller can hold any md/mf/mt instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- E_md_op  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is treated as none.
- E_A  in  32  forwarded rs value (dividend / multiplicand / mt source).
- E_B  in  32  forwarded rt value (divisor / multiplier).
- E_start  out  1  combinational: E_md_op in 1..4 and busy==0.
- E_busy  out  1  registered: an operation is in flight.
- E_md_stall  out  1  combinational: E_start | E_busy; consumed by the stall controller.
- E_HI  out  32  current HI register.
- E_LO  out  32  current LO register.

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, counter=0, busy=0, pending result=0. Applies immediately, including mid-operation; the in-flight result is discarded.
- Start:
  - On a rising edge with E_start==1, compute the result from E_A/E_B into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4). busy becomes 1 after this edge.
- Counting: each edge with counter>0 decrements it. busy = (counter!=0).
- Commit:
  - On the edge where the counter goes 1->0, HI<=pending_hi and LO<=pending_lo. busy falls on the same edge.
  - The new HI/LO are visible on the cycle after the last busy cycle. busy is high for exactly N cycles.
- HI/LO never change while busy, so mfhi/mflo issued during busy read the old values. The stall controller is responsible for preventing that.
- mult: {HI,LO} = signed(E_A)*signed(E_B), 64-bit. multu: unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero (E_B==0): LO=32'hFFFFFFFF, HI=E_A, for both signed and unsigned. The normal latency still applies.
- Signed overflow (div, E_A=32'h80000000, E_B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- mthi/mtlo:
  - When busy==0, HI (or LO) <= E_A on that edge; visible next cycle. No busy period.
  - When busy==1, the write is ignored.
- Op 1..4 while busy==1: ignored. No restart, counter undisturbed, E_start=0. E_md_stall is 1, so the pipeline never issues this.
- Same edge as the final commit (counter 1->0):
  - A new mult/div sees busy==1 and is ignored. The stall controller holds it one more cycle, and it then starts normally.
  - An mthi/mtlo on that edge is also ignored.
- Counter width: ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) bits; no wrap-around.

Test Plan:
- Reset then idle: hold reset low 2 cycles -> HI=0, LO=0, busy=0, E_md_stall=0. Assert reset low mid-divide -> busy=0 and HI/LO=0 immediately, with no later commit.
- mult signed: A=32'hFFFFFFFE (-2), B=3 -> E_start=1 for 1 cycle, busy=1 for exactly 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. multu with the same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- div signed: A=-7 (32'hFFFFFFF9), B=2 -> busy 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Corner divides: div A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0. divu A=5, B=0 -> LO=32'hFFFFFFFF, HI=5. Both take 10 cycles.
- Busy interference: start mult A=2, B=3. During busy, drive mthi A=32'h1234 and div A=9, B=3 -> both ignored and busy count unchanged; final HI=0, LO=6. E_md_stall=1 throughout.
- Back-to-back: drive div on the exact commit edge of a prior mult -> ignored. Drive it again the next cycle -> starts, busy=1 for 10 cycles. mtlo A=32'hABCD while idle -> LO=32'hABCD the next cycle, busy stays 0.
